vec_sdiv: RTL and testbench

VEC_SDIV -- requirements
Module: vec_sdiv

---
 rtl/vec_sdiv_if.sv | 14 +
 rtl/vec_sdiv.sv | 236 +++++++++++++++++++++++
 tb/tb_vec_sdiv.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vec_sdiv_if.sv
// Bus bundle for the 16-lane FP16 vector-by-scalar divider: command, operands, results and status.
interface vec_sdiv_if;
  logic         start;
  logic [15:0]  scalar;
  logic [255:0] vecin;
  logic [255:0] quotient;
  logic         busy;
  logic         done;
  logic         Ovf;
  logic         DivZ;

  modport master (output start, scalar, vecin, input quotient, busy, done, Ovf, DivZ);
  modport slave  (input start, scalar, vecin, output quotient, busy, done, Ovf, DivZ);
endinterface

// File: rtl/vec_sdiv.sv
// Sequential FP16 divider: divides 16 dividend lanes by one scalar, one lane at a time,
// with a fixed 15-cycle budget per lane (LOAD, 13 restoring-division steps, PACK).
module vec_sdiv (
  input  logic      clk,
  input  logic      rst_n,
  vec_sdiv_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] SPEC_NONE = 2'd0;
  localparam logic [1:0] SPEC_INF  = 2'd1;
  localparam logic [1:0] SPEC_ZERO = 2'd2;
  localparam logic [1:0] SPEC_DIVZ = 2'd3;

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       scalar_r;
  logic [255:0]      vec_r;
  logic [255:0]      quot_r;
  logic [3:0]        lane_r;
  logic [3:0]        cnt_r;
  logic [10:0]       mb_r;
  logic [11:0]       rem_r;
  logic [12:0]       q_r;
  logic signed [7:0] exp_r;
  logic              sign_r;
  logic [1:0]        spec_r;
  logic              busy_r;
  logic              done_r;
  logic              ovf_r;
  logic              divz_r;
  logic              busy_s;
  logic              done_s;

  logic [15:0]       a_s;
  logic signed [7:0] exp_s;
  logic [1:0]        spec_s;
  logic              ge_s;
  logic [10:0]       rem_sub_s;
  logic [11:0]       rem_step_s;
  logic [10:0]       mant_n_s;
  logic signed [7:0] e_n_s;
  logic              guard_s;
  logic              sticky_s;
  logic [9:0]        frac_s;
  logic signed [7:0] e_f_s;
  logic [15:0]       result_s;
  logic              ovf_hit_s;
  logic              divz_hit_s;

  assign a_s = vec_r[{lane_r, 4'b0000} +: 16];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; special-case lanes still spend the full 13 DIV cycles.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (bus.start) state_s = LOAD; else state_s = IDLE;
      LOAD: state_s = DIV;
      DIV:  if (cnt_r == 4'd12) state_s = PACK; else state_s = DIV;
      PACK: if (lane_r == 4'd15) state_s = DONE; else state_s = LOAD;
      DONE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decoded from the next state so the registered copies line up with it.
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // Operand unpack and special-case classification; first matching rule wins.
  always_comb begin
    exp_s = $signed({3'b000, a_s[14:10]}) - $signed({3'b000, scalar_r[14:10]}) + 8'sd15;
    if (a_s[14:10] == 5'h1F) begin
      spec_s = SPEC_INF;
    end else if (scalar_r[14:10] == 5'h1F) begin
      spec_s = SPEC_ZERO;
    end else if (scalar_r[14:10] == 5'h00) begin
      spec_s = SPEC_DIVZ;
    end else if (a_s[14:10] == 5'h00) begin
      spec_s = SPEC_ZERO;
    end else begin
      spec_s = SPEC_NONE;
    end
  end

  // One restoring-division step; the remainder always stays below twice the divisor.
  always_comb begin
    ge_s = (rem_r >= {1'b0, mb_r});
    if (ge_s) begin
      rem_sub_s = 11'(rem_r - {1'b0, mb_r});
    end else begin
      rem_sub_s = rem_r[10:0];
    end
    rem_step_s = {rem_sub_s, 1'b0};
  end

  // Normalise, round to nearest even, range-check and apply special-case overrides.
  always_comb begin
    if (q_r[12]) begin
      mant_n_s = q_r[12:2];
      guard_s  = q_r[1];
      sticky_s = q_r[0] | (rem_r != 12'd0);
      e_n_s    = exp_r;
    end else begin
      mant_n_s = q_r[11:1];
      guard_s  = q_r[0];
      sticky_s = (rem_r != 12'd0);
      e_n_s    = exp_r - 8'sd1;
    end
    if (guard_s & (sticky_s | mant_n_s[0])) begin
      if (mant_n_s == 11'h7FF) begin
        frac_s = 10'h000;
        e_f_s  = e_n_s + 8'sd1;
      end else begin
        frac_s = mant_n_s[9:0] + 10'd1;
        e_f_s  = e_n_s;
      end
    end else begin
      frac_s = mant_n_s[9:0];
      e_f_s  = e_n_s;
    end
    divz_hit_s = 1'b0;
    case (spec_r)
      SPEC_INF: begin
        result_s  = {sign_r, 5'h1F, 10'h000};
        ovf_hit_s = 1'b1;
      end
      SPEC_ZERO: begin
        result_s  = {sign_r, 15'h0000};
        ovf_hit_s = 1'b0;
      end
      SPEC_DIVZ: begin
        result_s   = {sign_r, 5'h1F, 10'h000};
        ovf_hit_s  = 1'b1;
        divz_hit_s = 1'b1;
      end
      default: begin
        if (e_f_s >= 8'sd31) begin
          result_s  = {sign_r, 5'h1F, 10'h000};
          ovf_hit_s = 1'b1;
        end else if (e_f_s <= 8'sd0) begin
          result_s  = {sign_r, 15'h0000};
          ovf_hit_s = 1'b0;
        end else begin
          result_s  = {sign_r, e_f_s[4:0], frac_s};
          ovf_hit_s = 1'b0;
        end
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scalar_r <= 16'h0000;
      vec_r    <= 256'd0;
      quot_r   <= 256'd0;
      lane_r   <= 4'd0;
      cnt_r    <= 4'd0;
      mb_r     <= 11'd0;
      rem_r    <= 12'd0;
      q_r      <= 13'd0;
      exp_r    <= 8'sd0;
      sign_r   <= 1'b0;
      spec_r   <= SPEC_NONE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      divz_r   <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            scalar_r <= bus.scalar;
            vec_r    <= bus.vecin;
            quot_r   <= 256'd0;
            lane_r   <= 4'd0;
            ovf_r    <= 1'b0;
            divz_r   <= 1'b0;
          end
        end
        LOAD: begin
          mb_r   <= {1'b1, scalar_r[9:0]};
          rem_r  <= {1'b0, 1'b1, a_s[9:0]};
          q_r    <= 13'd0;
          cnt_r  <= 4'd0;
          exp_r  <= exp_s;
          sign_r <= a_s[15] ^ scalar_r[15];
          spec_r <= spec_s;
        end
        DIV: begin
          rem_r <= rem_step_s;
          q_r   <= {q_r[11:0], ge_s};
          cnt_r <= cnt_r + 4'd1;
        end
        PACK: begin
          quot_r[{lane_r, 4'b0000} +: 16] <= result_s;
          if (ovf_hit_s) ovf_r <= 1'b1;
          if (divz_hit_s) divz_r <= 1'b1;
          lane_r <= lane_r + 4'd1;
        end
        DONE: begin
          lane_r <= 4'd0;
        end
        default: begin
          lane_r <= 4'd0;
        end
      endcase
    end
  end

  assign bus.quotient = quot_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.Ovf      = ovf_r;
  assign bus.DivZ     = divz_r;
endmodule

// File: tb/tb_vec_sdiv.sv
// Scoreboard bench for vec_sdiv: directed operations push expected results, a done monitor checks them.
module tb_vec_sdiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vec_sdiv_if bus();

  vec_sdiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] q;
    logic         ovf;
    logic         divz;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("quotient", bus.quotient, e.q);
        check("Ovf", 256'(bus.Ovf), 256'(e.ovf));
        check("DivZ", 256'(bus.DivZ), 256'(e.divz));
        check("done_latency", 256'(cyc - e.start_cyc), 256'd241);
        check("busy_at_done", 256'(bus.busy), 256'd1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic run_op(input logic [15:0] sc, input logic [255:0] v, input logic [255:0] eq,
                        input logic eo, input logic ed, input int ghost_at, input int abort_at);
    exp_t e;
    int   n;
    wait_idle();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.scalar = sc;
    bus.vecin  = v;
    e.q = eq;
    e.ovf = eo;
    e.divz = ed;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.scalar = 16'($urandom());
    bus.vecin  = {8{$urandom()}};
    check("busy_after_accept", 256'(bus.busy), 256'd1);
    check("quotient_cleared", bus.quotient, 256'd0);
    check("flags_cleared", 256'({bus.Ovf, bus.DivZ}), 256'd0);
    n = 1;
    while (bus.busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (n == ghost_at) begin
        bus.start  = 1'b1;
        bus.scalar = 16'h0000;
      end
      if (n == abort_at) begin
        e = exp_q.pop_back();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        n++;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        check("abort_busy", 256'(bus.busy), 256'd0);
        check("abort_done", 256'(bus.done), 256'd0);
        check("abort_quotient", bus.quotient, 256'd0);
        check("abort_flags", 256'({bus.Ovf, bus.DivZ}), 256'd0);
        @(negedge clk);
        check("start_during_reset_ignored", 256'(bus.busy), 256'd0);
        repeat (300) @(negedge clk);
      end
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: busy=%b required 0", bus.busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] v;
    logic [255:0] eq;
    bus.start  = 1'b0;
    bus.scalar = 16'h0000;
    bus.vecin  = 256'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 256'(bus.busy), 256'd0);
    check("reset_done", 256'(bus.done), 256'd0);
    check("reset_quotient", bus.quotient, 256'd0);
    check("reset_Ovf", 256'(bus.Ovf), 256'd0);
    check("reset_DivZ", 256'(bus.DivZ), 256'd0);
    rst_n = 1'b1;

    // 4/2 on every lane, with an ignored second start in cycle 50.
    run_op(16'h4000, {16{16'h4400}}, {16{16'h4000}}, 1'b0, 1'b0, 50, 0);

    // Divide by 3: RNE round-down, exact, zero, signed zero and round-up lanes.
    v = 256'd0;
    v[15:0] = 16'h3C00; v[31:16] = 16'hC400; v[47:32] = 16'h4200;
    v[79:64] = 16'h8000; v[95:80] = 16'h4500;
    eq = 256'd0;
    eq[15:0] = 16'h3555; eq[31:16] = 16'hBD55; eq[47:32] = 16'h3C00;
    eq[79:64] = 16'h8000; eq[95:80] = 16'h3EAB;
    run_op(16'h4200, v, eq, 1'b0, 1'b0, 0, 0);

    // Zero divisor: every lane becomes signed infinity.
    v = 256'd0;
    v[15:0] = 16'h3C00; v[31:16] = 16'h8000;
    eq = {16{16'h7C00}};
    eq[31:16] = 16'hFC00;
    run_op(16'h0000, v, eq, 1'b1, 1'b1, 0, 0);

    // Exponent overflow.
    v = 256'd0;
    v[15:0] = 16'h7BFF;
    eq = 256'd0;
    eq[15:0] = 16'h7C00;
    run_op(16'h1400, v, eq, 1'b1, 1'b0, 0, 0);

    // Underflow flushes to zero; plain halving on lane 1.
    v = 256'd0;
    v[15:0] = 16'h0400; v[31:16] = 16'h3C00;
    eq = 256'd0;
    eq[31:16] = 16'h3800;
    run_op(16'h4000, v, eq, 1'b0, 1'b0, 0, 0);

    // Infinite divisor gives zero unless the dividend is itself infinite.
    v = 256'd0;
    v[15:0] = 16'h3C00; v[31:16] = 16'h7C00; v[47:32] = 16'hBC00;
    eq = 256'd0;
    eq[31:16] = 16'h7C00; eq[47:32] = 16'h8000;
    run_op(16'h7C00, v, eq, 1'b1, 1'b0, 0, 0);

    // Reset in cycle 100 aborts a zero-divisor operation; then a normal run.
    v = 256'd0;
    v[15:0] = 16'h3C00; v[31:16] = 16'h8000;
    eq = {16{16'h7C00}};
    eq[31:16] = 16'hFC00;
    run_op(16'h0000, v, eq, 1'b1, 1'b1, 0, 100);
    run_op(16'h4000, {16{16'h4400}}, {16{16'h4000}}, 1'b0, 1'b0, 0, 0);

    wait_idle();
    repeat (5) @(negedge clk);
    check("pending_expectations", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
